// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes and an iterative shift-add multiplier.
// One operation in flight; the result and flags are held until the consumer takes them.
module alu_seq #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2:0]     S,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] F,
  output logic           zero,
  output logic           cout
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W:0] SHL_LIM = (W + 1)'(2 * W);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand, acc, acc_step;
  logic [W-1:0]   mplier;
  logic           accept, consume, is_mul, last_step;
  logic [2*W-1:0] op_f;
  logic           op_cout;
  logic [W:0]     sum, diff;

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign is_mul    = (S == 3'b010);
  assign last_step = (cnt == CW'(1));
  assign acc_step  = mplier[0] ? acc + mcand : acc;

  // Single-cycle operations, evaluated on the live operands and used only at accept.
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    op_f    = '0;
    op_cout = 1'b0;
    case (S)
      3'b000: begin
        op_f    = {{(W-1){1'b0}}, sum};
        op_cout = sum[W];
      end
      3'b001: begin
        op_f    = {{(W-1){diff[W]}}, diff};
        op_cout = (A < B);
      end
      3'b011: op_f = {{W{1'b0}}, A & B};
      3'b100: op_f = {{W{1'b0}}, A | B};
      3'b101: op_f = {{W{1'b0}}, A ^ B};
      3'b110: begin
        if ({1'b0, B} >= SHL_LIM) op_f = '0;
        else                      op_f = {{W{1'b0}}, A} << B;
      end
      3'b111: op_f = {{W{1'b0}}, A >> B};
      default: op_f = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mul) state_next = MUL;
      MUL:     if (last_step)        state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      F         <= '0;
      zero      <= 1'b0;
      cout      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        if (is_mul) begin
          mcand     <= {{W{1'b0}}, A};
          mplier    <= B;
          acc       <= '0;
          cnt       <= CW'(W);
          out_valid <= 1'b0;
        end else begin
          // A new result replaces one consumed on the same edge, so out_valid stays set.
          F         <= op_f;
          zero      <= (op_f == '0);
          cout      <= op_cout;
          out_valid <= 1'b1;
        end
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end else begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (last_step) begin
        F         <= acc_step;
        zero      <= (acc_step == '0);
        cout      <= 1'b0;
        out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: W=4 instance driven from a vector table through a result scoreboard,
// hand sequences for mul timing, mid-mul reset and backpressure, and a W=8 multiply.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       iv4, ir4, ov4, ordy4, z4, c4;
  logic [3:0] a4, b4;
  logic [2:0] s4;
  logic [7:0] f4;

  logic       iv8, ir8, ov8, ordy8, z8, c8;
  logic [7:0] a8, b8;
  logic [2:0] s8;
  logic [15:0] f8;

  alu_seq #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4), .S(s4),
    .out_valid(ov4), .out_ready(ordy4), .F(f4), .zero(z4), .cout(c4)
  );

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .S(s8),
    .out_valid(ov8), .out_ready(ordy8), .F(f8), .zero(z8), .cout(c8)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic [7:0] f;
    logic       z;
    logic       c;
  } vec_t;

  typedef struct {
    logic [7:0] f;
    logic       z;
    logic       c;
  } exp_t;

  exp_t exp_q[$];
  exp_t got;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: a result is consumed at the edge after a negedge where out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && ov4 && ordy4) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got F=%0h with no expected result", f4);
      end else begin
        got = exp_q.pop_front();
        check("sb_F", 32'(f4), 32'(got.f));
        check("sb_zero", 32'(z4), 32'(got.z));
        check("sb_cout", 32'(c4), 32'(got.c));
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                       input bit push, input logic [7:0] f, input logic z, input logic c);
    bit done;
    exp_t e;
    done = 0;
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    if (push) begin
      e.f = f; e.z = z; e.c = c;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ir4) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    iv4 = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send4_timeout: in_ready never rose for S=%0b", s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{4'hF, 4'hF, 3'b000, 8'h1E, 1'b0, 1'b1};
    vecs[1]  = '{4'hC, 4'hA, 3'b011, 8'h08, 1'b0, 1'b0};
    vecs[2]  = '{4'hC, 4'hA, 3'b100, 8'h0E, 1'b0, 1'b0};
    vecs[3]  = '{4'hC, 4'hA, 3'b101, 8'h06, 1'b0, 1'b0};
    vecs[4]  = '{4'h4, 4'h4, 3'b001, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{4'h3, 4'h5, 3'b001, 8'hFE, 1'b0, 1'b1};
    vecs[6]  = '{4'h1, 4'h7, 3'b110, 8'h80, 1'b0, 1'b0};
    vecs[7]  = '{4'h1, 4'h8, 3'b110, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{4'h8, 4'h3, 3'b111, 8'h01, 1'b0, 1'b0};
    vecs[9]  = '{4'h1, 4'h2, 3'b000, 8'h03, 1'b0, 1'b0};
    vecs[10] = '{4'hF, 4'hF, 3'b010, 8'hE1, 1'b0, 1'b0};
    vecs[11] = '{4'h3, 4'h0, 3'b010, 8'h00, 1'b1, 1'b0};
    vecs[12] = '{4'hF, 4'h4, 3'b110, 8'hF0, 1'b0, 1'b0};
    vecs[13] = '{4'h0, 4'hF, 3'b001, 8'hF1, 1'b0, 1'b1};
    vecs[14] = '{4'h9, 4'h7, 3'b010, 8'h3F, 1'b0, 1'b0};

    rst_n = 1'b0;
    iv4 = 1'b0; a4 = '0; b4 = '0; s4 = '0; ordy4 = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = '0; ordy8 = 1'b1;

    #12;
    check("rst_out_valid", 32'(ov4), 0);
    check("rst_F", 32'(f4), 0);
    check("rst_zero", 32'(z4), 0);
    check("rst_cout", 32'(c4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(ir4), 1);

    // Table of single results, back to back with out_ready high.
    @(posedge clk); #1;
    foreach (vecs[i])
      send4(vecs[i].a, vecs[i].b, vecs[i].s, 1, vecs[i].f, vecs[i].z, vecs[i].c);

    // Mul timing: four busy cycles, then result with in_ready back.
    @(posedge clk); #1;
    send4(4'hF, 4'hF, 3'b010, 1, 8'hE1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mul4_busy_in_ready", 32'(ir4), 0);
      check("mul4_busy_out_valid", 32'(ov4), 0);
    end
    @(negedge clk);
    check("mul4_done_out_valid", 32'(ov4), 1);
    check("mul4_done_F", 32'(f4), 32'h00E1);
    check("mul4_done_in_ready", 32'(ir4), 1);

    // Reset two step edges into a 9*7 multiply.
    @(posedge clk); #1;
    send4(4'h9, 4'h7, 3'b010, 0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midmul_rst_out_valid", 32'(ov4), 0);
    check("midmul_rst_F", 32'(f4), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midmul_rst_in_ready", 32'(ir4), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midmul_discarded", 32'(ov4), 0);
    end
    @(posedge clk); #1;
    send4(4'h1, 4'h1, 3'b000, 1, 8'h02, 1'b0, 1'b0);

    // Backpressure: hold an add result, then consume while accepting a sub.
    @(posedge clk); #1;
    ordy4 = 1'b0;
    send4(4'h2, 4'h3, 3'b000, 1, 8'h05, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_F", 32'(f4), 32'h05);
      check("hold_out_valid", 32'(ov4), 1);
      check("hold_in_ready", 32'(ir4), 0);
    end
    @(posedge clk); #1;
    ordy4 = 1'b1;
    a4 = 4'h7; b4 = 4'h2; s4 = 3'b001; iv4 = 1'b1;
    got.f = 8'h05; got.z = 1'b0; got.c = 1'b0;
    exp_q.push_back(got);
    @(posedge clk); #1;
    iv4 = 1'b0;
    check("swap_out_valid", 32'(ov4), 1);
    check("swap_F", 32'(f4), 32'h05);

    // W=8 multiply: eight step cycles before out_valid.
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; s8 = 3'b010; iv8 = 1'b1;
    @(negedge clk);
    check("mul8_in_ready", 32'(ir8), 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov8) break;
      n++;
    end
    check("mul8_latency", 32'(n), 8);
    check("mul8_F", 32'(f8), 32'hFE01);
    check("mul8_cout", 32'(c8), 0);
    check("mul8_zero", 32'(z8), 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. Adds a W-bit datapath, a 3-bit opcode with eight operations, an iterative shift-add multiplier and zero/carry flags. Input and output use valid/ready handshakes, so the block sits between an operand source and a result consumer in the arithmetic datapath. One operation is in flight at a time, and the result is held until it is consumed.

## Interface
- W, default 4: operand width; legal values W >= 2; result width is 2W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept operands this cycle
- A  in  W  operand A (unsigned)
- B  in  W  operand B (unsigned)
- S  in  3  opcode: 000 add, 001 sub, 010 mul, 011 and, 100 or, 101 xor, 110 shl, 111 shr
- out_valid  out  1  F/flags hold a valid result
- out_ready  in  1  consumer takes the result this cycle
- F  out  2W  result
- zero  out  1  F == 0
- cout  out  1  add carry-out / sub borrow; 0 for other ops

## Operation
- States are IDLE and MUL. out_valid is a separate register.
- in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational from state, out_valid and out_ready.
- Accept occurs when in_valid && in_ready at a rising edge. A, B and S are sampled only at accept.
- Result widths and flags:
  - add: F = zero-extended (W+1)-bit A+B; cout = bit W of the sum.
  - sub: F = (W+1)-bit A-B, sign-extended to 2W; cout = (A < B).
  - and/or/xor: F = zero-extended W-bit result.
  - shl: F = {W zeros, A} << B. F = 0 if B >= 2W.
  - shr: F = A >> B, zero-extended.
  - mul: F = unsigned 2W-bit A*B.
- Non-mul ops: at the accept edge, F, zero and cout load and out_valid is set. State stays IDLE.
- mul: at the accept edge, the multiplicand, multiplier and accumulator are loaded, and the step counter is loaded with W. State goes to MUL and out_valid clears.
- In MUL, each edge performs one step: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; then shift; then decrement the counter.
  - On the edge where the counter reaches 0: F loads the product, zero is updated, cout = 0, out_valid is set, and state returns to IDLE.
- Result consumption: out_valid && out_ready at an edge clears out_valid, unless a new non-mul accept happens on the same edge. In that case out_valid stays 1 and F takes the new result.
- While out_valid && !out_ready: F, zero and cout are held stable and in_ready = 0.
- In MUL, in_valid is ignored and in_ready = 0.
- Reset (asynchronous, any time, including mid-MUL):
  - state = IDLE, out_valid = 0, F = 0, zero = 0, cout = 0.
  - Counter and accumulator are cleared.
  - Any in-flight multiply is discarded.

## Timing
- Non-mul latency: accept at edge k gives out_valid = 1 after edge k.
- Throughput for non-mul ops: one per cycle when out_ready is held high.
- Mul latency: accept at edge k; steps occur on edges k+1 .. k+W; out_valid = 1 after edge k+W.
- in_ready is low from after edge k through edge k+W.
- Earliest next accept after a mul is at edge k+W+1, or at edge k+W+1 in the same cycle the result is consumed.
- F and the flags change only at an accept edge (non-mul), at the final MUL step, or at reset.
- Consuming a result on its own never changes F.
- Counter width is clog2(W+1).

## Test plan
- Reset: assert rst_n = 0 two cycles into a W=4 mul of 9*7 -> immediately out_valid = 0, F = 8'h00, in_ready = 1 after release; a following add of 1+1 gives F = 8'h02.
- Sub, W=4:
  - A = 4'b0100, B = 4'b0100, S = 001 -> one edge later out_valid = 1, F = 8'h00, zero = 1, cout = 0.
  - A = 3, B = 5 -> F = 8'hFE, cout = 1, zero = 0.
- Add/logic, W=4:
  - 15+15 -> F = 8'h1E, cout = 1.
  - A = 4'hC, B = 4'hA: and -> 8'h08, or -> 8'h0E, xor -> 8'h06, each on consecutive cycles with out_ready = 1.
- Mul, W=4: 15*15 -> in_ready = 0 for 4 cycles; out_valid rises after the 4th step edge with F = 8'hE1, cout = 0. Repeat with W=8: 255*255 -> F = 16'hFE01 after 8 steps.
- Shift, W=4:
  - shl A = 1, B = 7 -> F = 8'h80.
  - shl A = 1, B = 8 -> F = 8'h00, zero = 1.
  - shr A = 4'h8, B = 3 -> F = 8'h01.
- Backpressure: hold out_ready = 0 after an add result (F = 8'h05) -> F stays stable and in_ready = 0 for 5 cycles; then raise out_ready with in_valid and sub 7-2 on the same cycle -> after the edge out_valid remains 1 and F = 8'h05 (the new sub result).
